hex_display_sequencer: RTL

- Controller that shares the output-buffer access port between the single-cycle core's LSU and an autonomous hex-display engine.
- The engine accepts a 32-bit value over a valid/ready handshake and converts it to eight 7-segment digit patterns.
- It writes the patterns to HEX0..HEX7 (BASE_ADDR+0..+7) one per granted cycle.
- Sits between the LSU and the output buffer. CPU has priority, with bounded anti-starvation for the engine.

---
 rtl/hex_display_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/hex_display_sequencer.sv
// rtl/hex_display_sequencer.sv - output-buffer port arbiter with 32-bit hex display engine
// Optional HEX_LEADING_BLANK_EN blanks digits above the most significant non-zero nibble.
module hex_display_sequencer #(
   parameter logic [15:0] BASE_ADDR    = 16'h7020,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [15:0] i_cpu_addr,
   input  logic [31:0] i_cpu_wr_data,
   input  logic        i_cpu_wr_en,
   input  logic        i_cpu_io_rd,
   input  logic        i_hex_valid,
   input  logic [31:0] i_hex_value,
   output logic        o_hex_ready,
   output logic        o_done,
   output logic        o_busy,
   output logic        o_cpu_stall,
   output logic [15:0] o_buf_addr,
   output logic [31:0] o_buf_wr_data,
   output logic        o_buf_wr_en
);

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

   localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

   state_t      r_state, w_state_nxt;
   logic [2:0]  r_idx, w_idx_nxt;
   logic [3:0]  r_starve, w_starve_nxt;
   logic [31:0] r_value, w_value_nxt;
   logic        w_cpu_req;
   logic        w_eng_grant;
   logic [3:0]  w_nibble;
   logic [6:0]  w_digit;

   function automatic logic [6:0] f_seg(input logic [3:0] n);
      case (n)
         4'h0: f_seg = 7'h40;
         4'h1: f_seg = 7'h79;
         4'h2: f_seg = 7'h24;
         4'h3: f_seg = 7'h30;
         4'h4: f_seg = 7'h19;
         4'h5: f_seg = 7'h12;
         4'h6: f_seg = 7'h02;
         4'h7: f_seg = 7'h78;
         4'h8: f_seg = 7'h00;
         4'h9: f_seg = 7'h10;
         4'hA: f_seg = 7'h08;
         4'hB: f_seg = 7'h03;
         4'hC: f_seg = 7'h46;
         4'hD: f_seg = 7'h21;
         4'hE: f_seg = 7'h06;
         default: f_seg = 7'h0E;
      endcase
   endfunction

   assign w_cpu_req = i_cpu_wr_en | i_cpu_io_rd;
   assign w_nibble  = r_value[{r_idx, 2'b00} +: 4];

`ifdef HEX_LEADING_BLANK_EN
   logic [2:0] r_msd;
   logic [2:0] w_msd_in;

   always_comb begin
      w_msd_in = 3'd0;
      for (int k = 0; k < 8; k++) begin
         if (i_hex_value[4*k +: 4] != 4'h0) w_msd_in = 3'(k);
      end
   end

   // msd is captured alongside the value so later input changes cannot alter blanking
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                            r_msd <= 3'd0;
      else if (r_state == S_IDLE && i_hex_valid) r_msd <= w_msd_in;
   end

   assign w_digit = (r_idx > r_msd) ? 7'h7F : f_seg(w_nibble);
`else
   assign w_digit = f_seg(w_nibble);
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= S_IDLE;
         r_idx    <= 3'd0;
         r_starve <= 4'd0;
         r_value  <= 32'd0;
      end else begin
         r_state  <= w_state_nxt;
         r_idx    <= w_idx_nxt;
         r_starve <= w_starve_nxt;
         r_value  <= w_value_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_idx_nxt    = r_idx;
      w_starve_nxt = r_starve;
      w_value_nxt  = r_value;
      w_eng_grant  = 1'b0;
      o_hex_ready  = 1'b0;
      o_done       = 1'b0;
      o_busy       = 1'b0;
      o_cpu_stall  = 1'b0;

      case (r_state)
         S_IDLE: begin
            o_hex_ready  = 1'b1;
            w_starve_nxt = 4'd0;
            if (i_hex_valid) begin
               w_value_nxt = i_hex_value;
               w_idx_nxt   = 3'd0;
               w_state_nxt = S_WRITE;
            end
         end
         S_WRITE: begin
            o_busy      = 1'b1;
            w_eng_grant = !w_cpu_req || (r_starve == LP_LIMIT);
            if (w_eng_grant) begin
               o_cpu_stall  = w_cpu_req;
               w_idx_nxt    = r_idx + 3'd1;
               w_starve_nxt = 4'd0;
               if (r_idx == 3'd7) w_state_nxt = S_DONE;
            end else if (r_starve != LP_LIMIT) begin
               w_starve_nxt = r_starve + 4'd1;
            end
         end
         S_DONE: begin
            o_done       = 1'b1;
            o_busy       = 1'b1;
            w_starve_nxt = 4'd0;
            w_state_nxt  = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase

      // CPU path is a pure combinational pass-through whenever the engine is not granted
      if (w_eng_grant) begin
         o_buf_addr    = BASE_ADDR + {13'd0, r_idx};
         o_buf_wr_data = {25'd0, w_digit};
         o_buf_wr_en   = 1'b1;
      end else begin
         o_buf_addr    = i_cpu_addr;
         o_buf_wr_data = i_cpu_wr_data;
         o_buf_wr_en   = i_cpu_wr_en;
      end
   end

endmodule
